// File: rtl/dcache_store_buffer.sv
// In-order store buffer feeding the DCache write port, with RAW overlap detection for loads.
// Optional store-to-load forwarding is enabled by defining STORE_FWD_EN.
module dcache_store_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PADDR_W = 56,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DT_W    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_req_valid,
  output logic                       st_req_ready,
  input  logic [PADDR_W-1:0]         st_req_paddr,
  input  logic [DT_W-1:0]            st_req_datatype,
  input  logic [DATA_W-1:0]          st_req_data,
  output logic                       wr_req_valid,
  output logic [PADDR_W-1:0]         wr_req_paddr,
  output logic [DT_W-1:0]            wr_req_datatype,
  output logic [DATA_W-1:0]          wr_req_data,
  input  logic                       wr_resp_done,
  input  logic                       wr_resp_ready,
  input  logic                       ld_chk_valid,
  input  logic [PADDR_W-1:0]         ld_chk_paddr,
  input  logic [DT_W-1:0]            ld_chk_datatype,
  output logic                       ld_chk_hit,
  output logic                       ld_fwd_valid,
  output logic [DATA_W-1:0]          ld_fwd_data,
  output logic [$clog2(DEPTH):0]     sb_count,
  output logic                       sb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  logic [PADDR_W-1:0] paddr_q [DEPTH];
  logic [DT_W-1:0]    dtype_q [DEPTH];
  logic [DATA_W-1:0]  data_q  [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PW-1:0]      head_q, tail_q;
  logic [CW-1:0]      count_q;
  state_e             state_q;

  logic               wr_valid_q;
  logic [PADDR_W-1:0] wr_paddr_q;
  logic [DT_W-1:0]    wr_dtype_q;
  logic [DATA_W-1:0]  wr_data_q;

  logic enq, pop, raw_hit;

  // Readiness depends on count alone so a same-cycle pop never frees a slot early.
  assign st_req_ready = (count_q != CW'(DEPTH));
  assign enq          = st_req_valid & st_req_ready;
  assign pop          = (state_q == StIssue) & wr_resp_done;

  assign wr_req_valid    = wr_valid_q;
  assign wr_req_paddr    = wr_paddr_q;
  assign wr_req_datatype = wr_dtype_q;
  assign wr_req_data     = wr_data_q;
  assign sb_count        = count_q;
  assign sb_empty        = (count_q == '0) && (state_q == StIdle);

  // Payload storage carries no reset; occupancy is tracked by valid_q and count_q.
  always_ff @(posedge clk) begin
    if (enq) begin
      paddr_q[tail_q] <= st_req_paddr;
      dtype_q[tail_q] <= st_req_datatype;
      data_q[tail_q]  <= st_req_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      wr_valid_q <= 1'b0;
      wr_paddr_q <= '0;
      wr_dtype_q <= '0;
      wr_data_q  <= '0;
    end else begin
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase

      unique case (state_q)
        StIdle: begin
          if ((count_q != '0) && wr_resp_ready) begin
            state_q    <= StIssue;
            wr_valid_q <= 1'b1;
            wr_paddr_q <= paddr_q[head_q];
            wr_dtype_q <= dtype_q[head_q];
            wr_data_q  <= data_q[head_q];
          end
        end
        StIssue: begin
          // Dropping valid for one cycle after done keeps the arbiter from re-latching.
          if (wr_resp_done) begin
            state_q    <= StIdle;
            wr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          wr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Overlap is checked at 8-byte granularity against registered entries only.
  always_comb begin
    raw_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (paddr_q[i][PADDR_W-1:3] == ld_chk_paddr[PADDR_W-1:3])) begin
        raw_hit = 1'b1;
      end
    end
    raw_hit = raw_hit & ld_chk_valid;
  end

`ifdef STORE_FWD_EN
  logic          fwd_found, fwd_hit;
  logic [PW-1:0] fwd_idx;

  // Walk oldest to youngest so the last overlapping match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd_found = 1'b0;
    fwd_idx   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx] && (paddr_q[idx][PADDR_W-1:3] == ld_chk_paddr[PADDR_W-1:3])) begin
        fwd_found = 1'b1;
        fwd_idx   = idx;
      end
    end
  end

  assign fwd_hit      = ld_chk_valid & fwd_found &
                        (paddr_q[fwd_idx] == ld_chk_paddr) &
                        (dtype_q[fwd_idx] == ld_chk_datatype);
  assign ld_fwd_valid = fwd_hit;
  assign ld_fwd_data  = fwd_hit ? data_q[fwd_idx] : '0;
  assign ld_chk_hit   = raw_hit & ~fwd_hit;
`else
  logic unused_ld_bits;
  assign unused_ld_bits = ^{ld_chk_datatype, ld_chk_paddr[2:0]};
  assign ld_fwd_valid   = 1'b0;
  assign ld_fwd_data    = '0;
  assign ld_chk_hit     = raw_hit;
`endif

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Self-checking bench for dcache_store_buffer: scoreboarded drain order plus
// table-driven load-check vectors and hand-written multi-cycle sequences.
module tb_dcache_store_buffer;

  logic        clk, rst_n;
  logic        st_req_valid, st_req_ready;
  logic [55:0] st_req_paddr;
  logic [2:0]  st_req_datatype;
  logic [63:0] st_req_data;
  logic        wr_req_valid;
  logic [55:0] wr_req_paddr;
  logic [2:0]  wr_req_datatype;
  logic [63:0] wr_req_data;
  logic        wr_resp_done, wr_resp_ready;
  logic        ld_chk_valid;
  logic [55:0] ld_chk_paddr;
  logic [2:0]  ld_chk_datatype;
  logic        ld_chk_hit, ld_fwd_valid;
  logic [63:0] ld_fwd_data;
  logic [2:0]  sb_count;
  logic        sb_empty;

  dcache_store_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .st_req_valid    (st_req_valid),
    .st_req_ready    (st_req_ready),
    .st_req_paddr    (st_req_paddr),
    .st_req_datatype (st_req_datatype),
    .st_req_data     (st_req_data),
    .wr_req_valid    (wr_req_valid),
    .wr_req_paddr    (wr_req_paddr),
    .wr_req_datatype (wr_req_datatype),
    .wr_req_data     (wr_req_data),
    .wr_resp_done    (wr_resp_done),
    .wr_resp_ready   (wr_resp_ready),
    .ld_chk_valid    (ld_chk_valid),
    .ld_chk_paddr    (ld_chk_paddr),
    .ld_chk_datatype (ld_chk_datatype),
    .ld_chk_hit      (ld_chk_hit),
    .ld_fwd_valid    (ld_fwd_valid),
    .ld_fwd_data     (ld_fwd_data),
    .sb_count        (sb_count),
    .sb_empty        (sb_empty)
  );

  typedef struct packed {
    logic [55:0] paddr;
    logic [2:0]  dt;
    logic [63:0] data;
  } sb_t;

  typedef struct {
    logic        vld;
    logic [55:0] pa;
    logic [2:0]  dt;
    logic        hit;
  } ld_vec_t;

  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pops   = 0;

  // Write responder: auto mode pulses done resp_lat cycles after valid rises.
  logic auto_resp, auto_done, man_done;
  int   resp_lat;
  int   vcnt;
  assign wr_resp_done = auto_resp ? auto_done : man_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    auto_done = 1'b0;
    vcnt      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !wr_req_valid) begin
        vcnt      = 0;
        auto_done = 1'b0;
      end else begin
        vcnt++;
        auto_done = (vcnt == resp_lat + 1);
      end
    end
  end

  // Scoreboard and bubble monitor.
  initial begin
    logic prev_done;
    sb_t  e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) check("bubble", 64'(wr_req_valid), 64'd0);
        if (wr_req_valid && wr_resp_done) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got paddr 0x%0h, expected no write", wr_req_paddr);
          end else begin
            e = sb_q.pop_front();
            check("wr_paddr", 64'(wr_req_paddr), 64'(e.paddr));
            check("wr_dt", 64'(wr_req_datatype), 64'(e.dt));
            check("wr_data", wr_req_data, e.data);
          end
          n_pops++;
        end
        prev_done = wr_req_valid && wr_resp_done;
      end
    end
  end

  task automatic store(input logic [55:0] a, input logic [63:0] d, input logic [2:0] t,
                       output logic acc);
    sb_t e;
    @(posedge clk);
    #1;
    st_req_valid    = 1'b1;
    st_req_paddr    = a;
    st_req_data     = d;
    st_req_datatype = t;
    @(negedge clk);
    acc = st_req_ready;
    if (acc) begin
      e.paddr = a;
      e.dt    = t;
      e.data  = d;
      sb_q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    st_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!sb_empty && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(sb_empty), 64'd1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!wr_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(wr_req_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ld_vec_t ld_tab[6];
    logic    exp_v[8];
    logic    acc;
    int      pops0;

    ld_tab[0] = '{1'b1, 56'h200C, 3'd3, 1'b1};
    ld_tab[1] = '{1'b1, 56'h2010, 3'd3, 1'b0};
    ld_tab[2] = '{1'b0, 56'h2008, 3'd2, 1'b0};
    ld_tab[3] = '{1'b1, 56'h2008, 3'd2, 1'b1};
    ld_tab[4] = '{1'b1, 56'h2000, 3'd3, 1'b0};
    ld_tab[5] = '{1'b1, 56'h200F, 3'd1, 1'b1};
    exp_v     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    st_req_valid = 1'b0; st_req_paddr = '0; st_req_datatype = '0; st_req_data = '0;
    wr_resp_ready = 1'b0; ld_chk_valid = 1'b0; ld_chk_paddr = '0; ld_chk_datatype = '0;
    auto_resp = 1'b1; resp_lat = 3; man_done = 1'b0;

    // Reset state
    #3;
    check("rst_wr_valid", 64'(wr_req_valid), 64'd0);
    check("rst_ready", 64'(st_req_ready), 64'd1);
    check("rst_empty", 64'(sb_empty), 64'd1);
    check("rst_count", 64'(sb_count), 64'd0);
    check("rst_hit", 64'(ld_chk_hit), 64'd0);
    check("rst_fwd", 64'(ld_fwd_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_resp_ready = 1'b1;

    // Single store: latency and one-cycle drop after done
    store(56'h1000, 64'hAA, 3'd3, acc);
    check("t2_accept", 64'(acc), 64'd1);
    check("t2_valid[0]", 64'(wr_req_valid), 64'(exp_v[0]));
    for (int c = 1; c < 8; c++) begin
      @(posedge clk);
      #1;
      st_req_valid = 1'b0;
      @(negedge clk);
      check($sformatf("t2_valid[%0d]", c), 64'(wr_req_valid), 64'(exp_v[c]));
      if (c == 2) check("t2_count_c2", 64'(sb_count), 64'd1);
      if (c == 6) check("t2_count_c6", 64'(sb_count), 64'd0);
    end
    wait_empty("t2_empty");

    // Fill with the write port blocked
    wr_resp_ready = 1'b0;
    resp_lat = 0;
    for (int i = 0; i < 5; i++) begin
      store(56'h5000 + 56'(8 * i), 64'hD0 + 64'(i), 3'd3, acc);
      check($sformatf("t3_ready[%0d]", i), 64'(acc), 64'(i < 4));
    end
    cyc();
    check("t3_count_full", 64'(sb_count), 64'd4);
    check("t3_ready_full", 64'(st_req_ready), 64'd0);
    pops0 = n_pops;
    wr_resp_ready = 1'b1;
    wait_empty("t3_empty");
    check("t3_pops", 64'(n_pops - pops0), 64'd4);

    // Simultaneous enqueue and pop at count 2
    auto_resp = 1'b0;
    store(56'h4000, 64'hA1, 3'd3, acc);
    store(56'h4008, 64'hB2, 3'd3, acc);
    cyc();
    wait_valid("t4_issue");
    check("t4_count_pre", 64'(sb_count), 64'd2);
    begin
      sb_t e;
      @(posedge clk);
      #1;
      st_req_valid = 1'b1; st_req_paddr = 56'h4010; st_req_data = 64'hC3; st_req_datatype = 3'd3;
      man_done = 1'b1;
      @(negedge clk);
      check("t4_ready", 64'(st_req_ready), 64'd1);
      e.paddr = 56'h4010; e.dt = 3'd3; e.data = 64'hC3;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    st_req_valid = 1'b0;
    man_done = 1'b0;
    @(negedge clk);
    check("t4_count_post", 64'(sb_count), 64'd2);
    auto_resp = 1'b1;
    resp_lat = 1;
    wait_empty("t4_empty");

    // Load overlap checks
    auto_resp = 1'b0;
    wr_resp_ready = 1'b0;
    ld_chk_valid = 1'b1; ld_chk_paddr = 56'h2008; ld_chk_datatype = 3'd2;
    store(56'h2008, 64'h55, 3'd3, acc);
    check("t5_same_cycle_hit", 64'(ld_chk_hit), 64'd0);
    cyc();
    check("t5_next_cycle_hit", 64'(ld_chk_hit), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      ld_chk_valid = ld_tab[i].vld; ld_chk_paddr = ld_tab[i].pa; ld_chk_datatype = ld_tab[i].dt;
      @(negedge clk);
      check($sformatf("t5_hit[%0d]", i), 64'(ld_chk_hit), 64'(ld_tab[i].hit));
      check($sformatf("t5_fwd[%0d]", i), 64'(ld_fwd_valid), 64'd0);
    end
    // done while idle must not pop
    @(posedge clk);
    #1;
    man_done = 1'b1;
    @(posedge clk);
    #1;
    man_done = 1'b0;
    @(negedge clk);
    check("t5_idle_done_count", 64'(sb_count), 64'd1);
    auto_resp = 1'b1;
    resp_lat = 0;
    wr_resp_ready = 1'b1;
    wait_empty("t5_empty");
    @(posedge clk);
    #1;
    ld_chk_valid = 1'b1; ld_chk_paddr = 56'h200C; ld_chk_datatype = 3'd3;
    @(negedge clk);
    check("t5_hit_after_pop", 64'(ld_chk_hit), 64'd0);

    // Forwarding from the youngest matching store
    wr_resp_ready = 1'b0;
    store(56'h3000, 64'h11, 3'd3, acc);
    store(56'h3000, 64'h22, 3'd3, acc);
    cyc();
    @(posedge clk);
    #1;
    ld_chk_valid = 1'b1; ld_chk_paddr = 56'h3000; ld_chk_datatype = 3'd3;
    @(negedge clk);
`ifdef STORE_FWD_EN
    check("t6_fwd_valid", 64'(ld_fwd_valid), 64'd1);
    check("t6_fwd_data", ld_fwd_data, 64'h22);
    check("t6_hit", 64'(ld_chk_hit), 64'd0);
`else
    check("t6_fwd_valid", 64'(ld_fwd_valid), 64'd0);
    check("t6_fwd_data", ld_fwd_data, 64'd0);
    check("t6_hit", 64'(ld_chk_hit), 64'd1);
`endif
    @(posedge clk);
    #1;
    ld_chk_datatype = 3'd2;
    @(negedge clk);
    check("t6_dt_hit", 64'(ld_chk_hit), 64'd1);
    check("t6_dt_fwd", 64'(ld_fwd_valid), 64'd0);
    ld_chk_valid = 1'b0;
    wr_resp_ready = 1'b1;
    wait_empty("t6_empty");

    // Reset while a write is in flight
    auto_resp = 1'b0;
    store(56'h6000, 64'hE1, 3'd3, acc);
    store(56'h6008, 64'hE2, 3'd3, acc);
    cyc();
    wait_valid("t1_issue");
    check("t1_count_pre", 64'(sb_count), 64'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t1_async_valid", 64'(wr_req_valid), 64'd0);
    check("t1_async_ready", 64'(st_req_ready), 64'd1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_count_post", 64'(sb_count), 64'd0);
    check("t1_empty_post", 64'(sb_empty), 64'd1);
    check("t1_valid_post", 64'(wr_req_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
